// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and constants for the keypad matrix scanner.
//   state_e    : scan FSM states
//   *_BIT      : bit positions inside the 16-bit read word
//   EVT_W      : width of one stored key event
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      FRAME,
      EMIT
   } state_e;

   localparam int unsigned VALID_BIT = 15;
   localparam int unsigned OVF_BIT   = 14;
   localparam int unsigned REL_BIT   = 13;
   localparam int unsigned EVT_W     = 14;

endpackage

// File: rtl/keypad_evt_fifo.sv
// keypad_evt_fifo
//   Synchronous show-ahead FIFO holding key events.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push_i     : write data_i; accepted when not full, or when full with a pop in the same cycle
//   pop_i      : advance the head; ignored when empty
//   data_i     : event to store
//   data_o     : current head entry (valid while empty_o = 0)
//   full_o     : all DEPTH entries occupied
//   empty_o    : no entries stored
module keypad_evt_fifo #(
   parameter int unsigned WIDTH = 14,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             do_push, do_pop;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
//   Row/column matrix keypad scanner with frame debounce and a key-event FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   row_oe     : one-hot row drive enable (1 = drive row low), 0 outside row scanning
//   col_in     : raw pulled-up column pins, 0 = key closed on the driven row
//   cs, rd     : read select and one-cycle read strobe; cs & rd pops one event
//   rddat      : cs ? {not empty, overflow, head event} : 0
//   irq        : level, FIFO not empty
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned COLS       = 4,
   parameter int unsigned SCAN_DIV   = 125000,
   parameter int unsigned DEBOUNCE   = 3,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [ROWS-1:0] row_oe,
   input  logic [COLS-1:0] col_in,
   input  logic            cs,
   input  logic            rd,
   output logic [15:0]     rddat,
   output logic            irq
);

   localparam int unsigned N  = ROWS * COLS;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned DW = $clog2(SCAN_DIV);
   localparam int unsigned SW = $clog2(DEBOUNCE + 1);

   state_e           state_q, state_d;
   logic [COLS-1:0]  sync1_q, sync2_q;
   logic             run_q;
   logic [RW-1:0]    row_q, row_d;
   logic [DW-1:0]    div_q, div_d;
   logic [N-1:0]     raw_q, raw_d;
   logic [N-1:0]     prev_q, prev_d;
   logic [N-1:0]     deb_q, deb_d;
   logic [SW-1:0]    stable_q, stable_d;
   logic [KW-1:0]    k_q, k_d;
   logic             ovf_q, ovf_d;

   logic             push;
   logic [EVT_W-1:0] evt;
   logic             pop_req;
   logic             fifo_full, fifo_empty;
   logic [EVT_W-1:0] fifo_head;

   // State register and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SCAN;
         sync1_q  <= '1;
         sync2_q  <= '1;
         run_q    <= 1'b0;
         row_q    <= '0;
         div_q    <= '0;
         raw_q    <= '0;
         prev_q   <= '0;
         deb_q    <= '0;
         stable_q <= '0;
         k_q      <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= col_in;
         sync2_q  <= sync1_q;
         // Rows stay released during reset; scanning begins on the first clock after it.
         run_q    <= 1'b1;
         row_q    <= row_d;
         div_q    <= div_d;
         raw_q    <= raw_d;
         prev_q   <= prev_d;
         deb_q    <= deb_d;
         stable_q <= stable_d;
         k_q      <= k_d;
         ovf_q    <= ovf_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      div_d    = div_q;
      raw_d    = raw_q;
      prev_d   = prev_q;
      deb_d    = deb_q;
      stable_d = stable_q;
      k_d      = k_q;
      unique case (state_q)
         SCAN: begin
            if (run_q) begin
               if (div_q == DW'(SCAN_DIV - 1)) begin
                  div_d = '0;
                  for (int unsigned r = 0; r < ROWS; r++) begin
                     if (row_q == RW'(r)) raw_d[r*COLS +: COLS] = ~sync2_q;
                  end
                  if (row_q == RW'(ROWS - 1)) begin
                     row_d   = '0;
                     state_d = FRAME;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
         end
         FRAME: begin
            prev_d = raw_q;
            if (raw_q != prev_q)                stable_d = SW'(1);
            else if (stable_q != SW'(DEBOUNCE)) stable_d = stable_q + 1'b1;
            if ((stable_d == SW'(DEBOUNCE)) && (raw_q != deb_q)) begin
               state_d = EMIT;
               k_d     = '0;
            end else begin
               state_d = SCAN;
            end
         end
         EMIT: begin
            if (raw_q[k_q] != deb_q[k_q]) deb_d[k_q] = raw_q[k_q];
            if (k_q == KW'(N - 1)) state_d = SCAN;
            else                   k_d     = k_q + 1'b1;
         end
         default: state_d = SCAN;
      endcase
   end

   // Outputs of the FSM.
   always_comb begin
      row_oe = '0;
      push   = 1'b0;
      evt    = '0;
      if ((state_q == SCAN) && run_q) row_oe[row_q] = 1'b1;
      if (state_q == EMIT) begin
         push         = (raw_q[k_q] != deb_q[k_q]);
         evt[REL_BIT] = ~raw_q[k_q];
         evt[KW-1:0]  = k_q;
      end
   end

   assign pop_req = cs & rd;

   // A read strobe always clears overflow; a drop only happens when no pop frees a slot.
   always_comb begin
      ovf_d = ovf_q;
      if (pop_req)                 ovf_d = 1'b0;
      else if (push && fifo_full) ovf_d = 1'b1;
   end

   keypad_evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop_req),
      .data_i  (evt),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign irq = ~fifo_empty;

   always_comb begin
      rddat = '0;
      if (cs) begin
         rddat[VALID_BIT] = ~fifo_empty;
         rddat[OVF_BIT]   = ovf_q;
         if (!fifo_empty) rddat[EVT_W-1:0] = fifo_head;
      end
   end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
module tb_keypad_matrix_scanner;

   localparam int unsigned FRAME_CYC = 33;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  row_oe;
   logic [3:0]  col_in;
   logic        cs;
   logic        rd;
   logic [15:0] rddat;
   logic        irq;

   logic [15:0] keys;          // keys[r*4+c] = 1 -> switch closed
   logic [13:0] sb[$];         // expected events, in order
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   // Keypad model: a closed key pulls its column low while its row is driven.
   always_comb begin
      col_in = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (row_oe[r] && keys[r*4+c]) col_in[c] = 1'b0;
   end

   keypad_matrix_scanner #(
      .ROWS       (4),
      .COLS       (4),
      .SCAN_DIV   (8),
      .DEBOUNCE   (3),
      .FIFO_DEPTH (4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .row_oe (row_oe),
      .col_in (col_in),
      .cs     (cs),
      .rd     (rd),
      .rddat  (rddat),
      .irq    (irq)
   );

   task automatic wait_irq(input int unsigned max_cyc, output bit ok);
      ok = 1'b0;
      for (int unsigned i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (irq === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Returns at the first negedge of row 0 following a non-scanning interval.
   task automatic wait_frame_start(output bit ok);
      bit seen_idle = 1'b0;
      ok = 1'b0;
      for (int unsigned i = 0; i < 3 * FRAME_CYC; i++) begin
         @(negedge clk);
         if (row_oe == 4'b0000) seen_idle = 1'b1;
         else if (seen_idle && row_oe == 4'b0001) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pop_once();
      cs = 1'b1;
      rd = 1'b1;
      @(posedge clk);
      #1;
      rd = 1'b0;
      cs = 1'b0;
   endtask

   // Compare the FIFO head with the oldest expected event, then pop it.
   task automatic read_event(input string name);
      logic [13:0] exp;
      bit          ok;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s: no expected event queued", name);
         return;
      end
      exp = sb.pop_front();
      wait_irq(8 * FRAME_CYC, ok);
      cs = 1'b1;
      #1;
      if (!ok || {rddat[15], rddat[13:0]} !== {1'b1, exp}) begin
         n_fail++;
         $display("FAIL %s: rddat=%h irq_seen=%0d expected valid event %h", name, rddat, ok, exp);
      end
      pop_once();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      cs = 1'b1;
      rd = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (row_oe !== 4'b0000 || irq !== 1'b0 || rddat !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_state: row_oe=%b irq=%b rddat=%h expected 0000 0 0000", row_oe, irq, rddat);
      end
      cs = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (row_oe !== 4'b0001) begin
            n_fail++;
            $display("FAIL row0_period[%0d]: row_oe=%b expected 0001", i, row_oe);
         end
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (row_oe !== 4'b0010) begin
         n_fail++;
         $display("FAIL row1_start: row_oe=%b expected 0010", row_oe);
      end
      n_checks++;
      if (rddat !== 16'h0000) begin
         n_fail++;
         $display("FAIL cs_low_bus: rddat=%h expected 0000", rddat);
      end
   endtask

   task automatic test_single_key();
      bit ok;
      keys[6] = 1'b1;
      sb.push_back(14'h0006);
      wait_irq(4 * FRAME_CYC + 17, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL press_latency: irq=%b expected 1 within 4 frames", irq);
      end
      cs = 1'b1;
      #1;
      n_checks++;
      if (rddat !== {2'b10, sb[0]}) begin
         n_fail++;
         $display("FAIL press_word: rddat=%h expected 8006", rddat);
      end
      void'(sb.pop_front());
      pop_once();
      cs = 1'b1;
      #1;
      n_checks++;
      if (irq !== 1'b0 || rddat !== 16'h0000) begin
         n_fail++;
         $display("FAIL after_pop: irq=%b rddat=%h expected 0 0000", irq, rddat);
      end
      cs = 1'b0;
      keys[6] = 1'b0;
      sb.push_back(14'h2006);
      read_event("release_k6");
   endtask

   task automatic test_bounce();
      bit ok;
      for (int i = 0; i < 6; i++) begin
         wait_frame_start(ok);
         keys[6] = (i % 2 == 0);
         n_checks++;
         if (!ok || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_frame[%0d]: irq=%b frame_seen=%0d expected irq 0", i, irq, ok);
         end
      end
      repeat (5 * FRAME_CYC) @(negedge clk);
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce_settle: irq=%b expected 0", irq);
      end
   endtask

   task automatic test_multi_key();
      bit ok;
      wait_frame_start(ok);
      keys[0] = 1'b1;
      keys[5] = 1'b1;
      keys[15] = 1'b1;
      sb.push_back(14'h0000);
      sb.push_back(14'h0005);
      sb.push_back(14'h000F);
      wait_irq(5 * FRAME_CYC, ok);
      repeat (20) @(negedge clk);
      read_event("multi_k0");
      read_event("multi_k5");
      read_event("multi_k15");
      #1;
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL multi_count: irq=%b expected 0 after three reads", irq);
      end
      keys = '0;
      sb.push_back(14'h2000);
      sb.push_back(14'h2005);
      sb.push_back(14'h200F);
      read_event("multi_rel_k0");
      read_event("multi_rel_k5");
      read_event("multi_rel_k15");
   endtask

   task automatic test_overflow();
      bit ok;
      keys = 16'h019E;   // k = 1,2,3,4,7,8
      sb.push_back(14'h0001);
      sb.push_back(14'h0002);
      sb.push_back(14'h0003);
      sb.push_back(14'h0004);
      wait_irq(5 * FRAME_CYC, ok);
      repeat (20) @(negedge clk);
      cs = 1'b1;
      #1;
      n_checks++;
      if (!ok || rddat[15:14] !== 2'b11) begin
         n_fail++;
         $display("FAIL ovf_set: rddat=%h expected bits[15:14]=11", rddat);
      end
      cs = 1'b0;
      read_event("ovf_k1");
      cs = 1'b1;
      #1;
      n_checks++;
      if (rddat[14] !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: rddat=%h expected bit14=0", rddat);
      end
      cs = 1'b0;
      read_event("ovf_k2");
      read_event("ovf_k3");
      read_event("ovf_k4");
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_drained: irq=%b expected 0", irq);
      end
   endtask

   task automatic test_reset_in_emit();
      bit ok;
      bit hit;
      int unsigned idle;
      keys = '0;
      do_reset();
      repeat (2 * FRAME_CYC) @(negedge clk);
      keys[3] = 1'b1;
      hit = 1'b0;
      idle = 0;
      // Two consecutive idle-row cycles means FRAME then the first EMIT cycle.
      for (int unsigned i = 0; i < 6 * FRAME_CYC; i++) begin
         @(negedge clk);
         if (row_oe == 4'b0000) idle++;
         else idle = 0;
         if (idle == 2) begin
            hit = 1'b1;
            break;
         end
      end
      rst_n = 1'b0;
      cs = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (!hit || irq !== 1'b0 || rddat !== 16'h0000 || row_oe !== 4'b0000) begin
         n_fail++;
         $display("FAIL emit_reset: hit=%0d irq=%b rddat=%h row_oe=%b expected 0 0000 0000", hit, irq, rddat, row_oe);
      end
      rst_n = 1'b1;
      cs = 1'b0;
      repeat (FRAME_CYC + 8) @(negedge clk);
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++;
         $display("FAIL emit_reset_noevt: irq=%b expected 0", irq);
      end
      sb.push_back(14'h0003);
      read_event("rereport_k3");
   endtask

   initial begin
      keys = '0;
      cs = 1'b0;
      rd = 1'b0;
      rst_n = 1'b0;
      test_reset();
      test_single_key();
      test_bounce();
      test_multi_key();
      test_overflow();
      test_reset_in_emit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
